// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_ctrl
//  Purpose  : Button-sequenced operand/opcode loader with a registered ALU.
//             Each raw button is debounced into a single load pulse. The
//             pulses load A, B and the opcode. An opcode load triggers one
//             EXEC cycle that registers the result and the status flags. In
//             chain mode the result is also written back into A.
//  Ports    : clk        system clock, rising edge
//             i_rst      synchronous reset, active-low
//             i_btn[2:0] raw buttons: [0] load A, [1] load B, [2] load op+exec
//             i_sw_data  switch data (signed operand / opcode in low bits)
//             i_chain    1 = execute writes result back into A
//             o_led      registered result
//             o_valid    result matches current A/B/op
//             o_zero     result == 0
//             o_carry    carry (ADD) / borrow (SUB)
//             o_ovf      signed overflow (ADD/SUB)
//             o_err      last executed opcode unsupported
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int NB_DBNC     = 20,
    parameter int DBNC_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [2:0]         i_btn,
    input  logic [NB_DATA-1:0] i_sw_data,
    input  logic               i_chain,
    output logic [NB_DATA-1:0] o_led,
    output logic               o_valid,
    output logic               o_zero,
    output logic               o_carry,
    output logic               o_ovf,
    output logic               o_err
);

    localparam int               c_SHW      = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [NB_DBNC-1:0] c_DBNC    = NB_DBNC'(DBNC_CYCLES);
    localparam logic [NB_DBNC-1:0] c_DBNC_M1 = NB_DBNC'(DBNC_CYCLES - 1);

    localparam logic [NB_OP-1:0] c_OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] c_OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] c_OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] c_OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] c_OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] c_OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] c_OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] c_OP_SRL = NB_OP'(6'b000010);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2:0] w_pulse;

    // ------------------------------------------------------------------
    // Debounce: the pulse is registered in the edge where the counter
    // reaches DBNC_CYCLES; the armed flag keeps a held button from
    // firing again until it is released.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dbnc
            logic [NB_DBNC-1:0] r_cnt;
            logic               r_armed;
            logic               r_pulse;

            always_ff @(posedge clk) begin
                if (!i_rst || !i_btn[gi]) begin
                    r_cnt   <= '0;
                    r_armed <= 1'b0;
                    r_pulse <= 1'b0;
                end else begin
                    r_pulse <= 1'b0;
                    if (r_cnt != c_DBNC) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if ((r_cnt == c_DBNC_M1) && !r_armed) begin
                        r_pulse <= 1'b1;
                        r_armed <= 1'b1;
                    end
                end
            end

            assign w_pulse[gi] = r_pulse;
        end
    endgenerate

    // Fixed priority; losing pulses are dropped, not queued.
    logic w_ld_a, w_ld_b, w_ld_op;
    assign w_ld_a  = w_pulse[0];
    assign w_ld_b  = w_pulse[1] & ~w_pulse[0];
    assign w_ld_op = w_pulse[2] & ~w_pulse[1] & ~w_pulse[0];

    logic [NB_DATA-1:0] r_a, r_b;
    logic [NB_OP-1:0]   r_op;
    logic [NB_DATA-1:0] r_led;
    logic               r_valid, r_zero, r_carry, r_ovf, r_err;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [NB_DATA:0]   w_sum, w_diff;
    logic [c_SHW-1:0]   w_shamt;
    logic [NB_DATA-1:0] w_res;
    logic               w_carry, w_ovf, w_err;

    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff  = {1'b0, r_a} - {1'b0, r_b};   // MSB is the unsigned borrow
    assign w_shamt = r_b[c_SHW-1:0];

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_res   = w_sum[NB_DATA-1:0];
                w_carry = w_sum[NB_DATA];
                w_ovf   = (r_a[NB_DATA-1] == r_b[NB_DATA-1]) &&
                          (w_sum[NB_DATA-1] != r_a[NB_DATA-1]);
            end
            c_OP_SUB: begin
                w_res   = w_diff[NB_DATA-1:0];
                w_carry = w_diff[NB_DATA];
                w_ovf   = (r_a[NB_DATA-1] != r_b[NB_DATA-1]) &&
                          (w_diff[NB_DATA-1] != r_a[NB_DATA-1]);
            end
            c_OP_AND: w_res = r_a & r_b;
            c_OP_OR:  w_res = r_a | r_b;
            c_OP_XOR: w_res = r_a ^ r_b;
            c_OP_NOR: w_res = ~(r_a | r_b);
            c_OP_SRA: w_res = $signed(r_a) >>> w_shamt;
            c_OP_SRL: w_res = r_a >> w_shamt;
            default:  w_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_ld_op) w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_led   <= '0;
            r_valid <= 1'b0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_ld_a) begin
                r_a     <= i_sw_data;
                r_valid <= 1'b0;
            end else if (w_ld_b) begin
                r_b     <= i_sw_data;
                r_valid <= 1'b0;
            end else if (w_ld_op) begin
                r_op    <= i_sw_data[NB_OP-1:0];
                r_valid <= 1'b0;
            end
        end else begin
            r_led   <= w_res;
            r_zero  <= (w_res == '0);
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
            r_err   <= w_err;
            r_valid <= 1'b1;
            if (i_chain) begin
                r_a <= w_res;
            end
        end
    end

    assign o_led   = r_led;
    assign o_valid = r_valid;
    assign o_zero  = r_zero;
    assign o_carry = r_carry;
    assign o_ovf   = r_ovf;
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequenced operand/opcode front-end with an integrated registered ALU for the board-level ALU exercise.
- Takes raw push-buttons and switches, debounces each button and converts every press into a single load pulse.
- Loads A, B and opcode, then executes one registered ALU operation with status flags and a result-valid indication.
- Optional chain mode feeds the result back into A for accumulator-style sequences.

Parameters:
- NB_DATA, 8, operand/result width (signed two's complement).
- NB_OP, 6, opcode width; the opcode is taken from i_sw_data[NB_OP-1:0] (requires NB_OP <= NB_DATA).
- NB_DBNC, 20, debounce counter width.
- DBNC_CYCLES, 1000000, consecutive high cycles a button needs to register a press (must be < 2^NB_DBNC).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- i_rst  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk).
- i_btn  input  3  raw buttons: [0] load A, [1] load B, [2] load opcode + execute.
- i_sw_data  input  NB_DATA  switch data, signed.
- i_chain  input  1  1 = execute writes result back into A.
- o_led  output  NB_DATA  registered signed result.
- o_valid  output  1  result corresponds to the current A/B/op.
- o_zero  output  1  result == 0.
- o_carry  output  1  carry-out (ADD) / borrow (SUB), else 0.
- o_ovf  output  1  signed overflow (ADD/SUB), else 0.
- o_err  output  1  last executed opcode was unsupported.

Behaviour:
- Reset (i_rst=0 at clk edge): A, B, op, o_led = 0; o_valid, o_zero, o_carry, o_ovf, o_err = 0; FSM = IDLE; all debounce counters cleared; all press-armed flags cleared. Reset overrides everything, including an in-progress EXEC.
- Debounce, per button:
  - Counter increments while raw input is 1 and saturates at DBNC_CYCLES.
  - Any cycle with input 0 clears the counter and the armed flag.
  - A one-cycle pulse fires in the cycle the counter reaches DBNC_CYCLES; the armed flag then blocks further pulses until release.
  - Glitches shorter than DBNC_CYCLES produce no pulse.
- Pulse priority in the same cycle: btn0 > btn1 > btn2. Lower-priority pulses in that cycle are discarded, not queued.
- FSM has 2 states, IDLE and EXEC:
  - IDLE, pulse A: A <= i_sw_data; o_valid <= 0; o_led and flags hold.
  - IDLE, pulse B: B <= i_sw_data; o_valid <= 0.
  - IDLE, pulse OP: op <= i_sw_data[NB_OP-1:0]; o_valid <= 0; next state EXEC.
  - EXEC, one cycle: o_led, flags and o_valid <= 1 register the ALU result of current A, B, op. If i_chain=1, A <= result in the same edge. Next state IDLE. Pulses arriving during EXEC are discarded.
- Latency: o_valid rises 2 clk edges after the edge where the OP pulse is first seen high.
- Opcodes (6-bit):
  - ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111.
  - SRA 000011: A >>> B[2:0] for NB_DATA=8; generally the low ceil(log2 NB_DATA) bits of B.
  - SRL 000010: A >> same shift amount.
  - Any other opcode: result 0, o_err=1, o_zero=1, carry/ovf 0.
  - o_err clears on the next supported execute.
- Arithmetic:
  - Result truncated to NB_DATA.
  - carry = bit NB_DATA of the unsigned {0,A}+{0,B}. For SUB, carry = borrow (A <u B).
  - ovf = sign(A)==sign(±B) && sign(result)!=sign(A).
- Wrap-around: 127+1 gives 0x80 with ovf=1, carry=0. 0xFF+0x01 gives 0x00 with carry=1, zero=1, ovf=0.

Test Plan (DBNC_CYCLES=4):
- Reset with i_rst=0 for 2 cycles while buttons are held -> all outputs 0, no load occurs; after release of reset, buttons still held → a pulse fires only after 4 stable cycles.
- Glitch btn0 high 3 cycles then low, sw=0x55 -> A unchanged; hold 6 cycles -> exactly one load, A=0x55.
- A=0x7F, B=0x01, op=ADD -> o_led=0x80, o_ovf=1, o_carry=0, o_zero=0, o_valid=1 two edges after the OP pulse.
- A=0x05, B=0x07, op=SUB -> o_led=0xFE, carry(borrow)=1, ovf=0; then load B=0x02 -> o_valid=0 while o_led holds 0xFE.
- i_chain=1, A=0x01, B=0x01, ADD executed 3 times (OP pressed 3 times) -> o_led 0x02, 0x03, 0x04; A ends at 0x04.
- btn0 and btn1 reach threshold in the same cycle -> only A loads; op=111111 -> o_led=0, o_err=1, o_zero=1; then op=AND with A=0xF0, B=0x3C -> o_led=0x30, o_err=0.
